// File: rtl/detector_jogada_if.sv
// ============================================================================
// Module      : detector_jogada_if
// Description : Button inputs and move outputs of the player-move front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface detector_jogada_if #(
    parameter int N = 4
);
    logic         habilita;
    logic [N-1:0] botoes;
    logic [N-1:0] jogada;
    logic         jogada_feita;
    logic         erro_multipla;
    logic         ocupado;

    modport master (
        output habilita, botoes,
        input  jogada, jogada_feita, erro_multipla, ocupado
    );

    modport slave (
        input  habilita, botoes,
        output jogada, jogada_feita, erro_multipla, ocupado
    );
endinterface

`default_nettype wire

// File: rtl/detector_jogada.sv
// ============================================================================
// Module      : detector_jogada
// Description : Debounces N game buttons and emits a one-hot move plus strobe.
//               Define DETECTOR_JOGADA_SYNC_EN to add a 2-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module detector_jogada #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  wire logic         clock,
    input  wire logic         clear_n,
    detector_jogada_if.slave  bus
);

    localparam int                c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ocioso      = 2'd0;
    localparam logic [1:0] c_filtrando   = 2'd1;
    localparam logic [1:0] c_pressionado = 2'd2;
    localparam logic [1:0] c_soltando    = 2'd3;

    logic [N-1:0]       w_botoes_s;
    logic               w_onehot;
    logic [1:0]         r_state;
    logic [N-1:0]       r_snap;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-1:0]       r_jogada;
    logic               r_jogada_feita;
    logic               r_erro_multipla;
    logic               r_ocupado;

`ifdef DETECTOR_JOGADA_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.botoes;
            r_sync2 <= r_sync1;
        end
    end

    assign w_botoes_s = r_sync2;
`else
    assign w_botoes_s = bus.botoes;
`endif

    // snap is never zero while filtering, so clearing the lowest set bit tests one-hot
    assign w_onehot = ((r_snap & (r_snap - N'(1))) == '0);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state         <= c_ocioso;
            r_snap          <= '0;
            r_cnt           <= '0;
            r_jogada        <= '0;
            r_jogada_feita  <= 1'b0;
            r_erro_multipla <= 1'b0;
            r_ocupado       <= 1'b0;
        end else begin
            r_jogada_feita  <= 1'b0;
            r_erro_multipla <= 1'b0;
            case (r_state)
                c_ocioso: begin
                    if (bus.habilita && (w_botoes_s != '0)) begin
                        r_snap    <= w_botoes_s;
                        r_cnt     <= '0;
                        r_state   <= c_filtrando;
                        r_ocupado <= 1'b1;
                    end
                end
                c_filtrando: begin
                    if (w_botoes_s == '0) begin
                        r_state   <= c_ocioso;
                        r_ocupado <= 1'b0;
                    end else if (w_botoes_s != r_snap) begin
                        r_snap <= w_botoes_s;
                        r_cnt  <= '0;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        if (w_onehot) begin
                            r_jogada       <= r_snap;
                            r_jogada_feita <= 1'b1;
                        end else begin
                            r_erro_multipla <= 1'b1;
                        end
                        r_state <= c_pressionado;
                    end
                end
                c_pressionado: begin
                    if (w_botoes_s == '0) begin
                        r_cnt   <= '0;
                        r_state <= c_soltando;
                    end
                end
                c_soltando: begin
                    if (w_botoes_s != '0) begin
                        r_state <= c_pressionado;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state   <= c_ocioso;
                        r_ocupado <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_ocioso;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign bus.jogada        = r_jogada;
    assign bus.jogada_feita  = r_jogada_feita;
    assign bus.erro_multipla = r_erro_multipla;
    assign bus.ocupado       = r_ocupado;

endmodule

`default_nettype wire

// File: tb/tb_detector_jogada.sv
// ============================================================================
// Module      : tb_detector_jogada
// Description : Directed and random stimulus for detector_jogada against a
//               run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detector_jogada;

    localparam int N = 4;
    localparam int D = 4;
`ifdef DETECTOR_JOGADA_SYNC_EN
    localparam int c_lat = 2;
`else
    localparam int c_lat = 0;
`endif

    logic clock   = 1'b0;
    logic clear_n = 1'b0;

    detector_jogada_if #(.N(N)) bus();

    detector_jogada #(
        .N               (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n_feita, n_err, n_step, first_feita;
    logic prev_strobe = 1'b0;

    // Reference model: 0 idle, 1 filtering, 2 held, 3 releasing; m_run counts
    // consecutive edges seeing the same level since the phase began.
    int           m_mode = 0;
    int           m_run  = 0;
    logic [N-1:0] m_cand = '0;
    logic [N-1:0] m_p0   = '0;
    logic [N-1:0] m_p1   = '0;
    logic [N-1:0] e_jog  = '0;
    logic         e_feita = 1'b0;
    logic         e_err   = 1'b0;
    logic         e_ocup  = 1'b0;

    task automatic model_edge();
        logic [N-1:0] b;
        if (!clear_n) begin
            m_mode = 0; m_run = 0; m_cand = '0; m_p0 = '0; m_p1 = '0;
            e_jog = '0; e_feita = 1'b0; e_err = 1'b0; e_ocup = 1'b0;
            return;
        end
        if (c_lat == 2) begin
            b    = m_p1;
            m_p1 = m_p0;
            m_p0 = bus.botoes;
        end else begin
            b = bus.botoes;
        end
        e_feita = 1'b0;
        e_err   = 1'b0;
        case (m_mode)
            0: if (bus.habilita && b != 0) begin m_mode = 1; m_cand = b; m_run = 1; end
            1: begin
                if (b == 0) m_mode = 0;
                else if (b != m_cand) begin m_cand = b; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run == D + 1) begin
                        if ($countones(m_cand) == 1) begin e_jog = m_cand; e_feita = 1'b1; end
                        else e_err = 1'b1;
                        m_mode = 2;
                    end
                end
            end
            2: if (b == 0) begin m_mode = 3; m_run = 1; end
            default: begin
                if (b != 0) m_mode = 2;
                else begin
                    m_run++;
                    if (m_run == D + 1) m_mode = 0;
                end
            end
        endcase
        e_ocup = (m_mode != 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic strobe;
        @(posedge clock);
        model_edge();
        #1;
        n_step++;
        chk("jogada",        32'(bus.jogada),        32'(e_jog));
        chk("jogada_feita",  32'(bus.jogada_feita),  32'(e_feita));
        chk("erro_multipla", 32'(bus.erro_multipla), 32'(e_err));
        chk("ocupado",       32'(bus.ocupado),       32'(e_ocup));
        strobe = bus.jogada_feita | bus.erro_multipla;
        chk("strobe_excl",   32'(bus.jogada_feita & bus.erro_multipla), 32'd0);
        chk("strobe_gap",    32'(prev_strobe & strobe), 32'd0);
        prev_strobe = strobe;
        if (bus.jogada_feita === 1'b1) begin
            n_feita++;
            if (first_feita < 0) first_feita = n_step;
        end
        if (bus.erro_multipla === 1'b1) n_err++;
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        bus.botoes = b;
        repeat (n) step();
    endtask

    task automatic clr_cnt();
        n_feita = 0; n_err = 0; n_step = 0; first_feita = -1;
    endtask

    initial begin
        logic [N-1:0] rb;
        int           r;

        clr_cnt();
        bus.habilita = 1'b0;
        bus.botoes   = '0;
        clear_n      = 1'b0;
        repeat (2) step();
        chk("rst_jogada",  32'(bus.jogada),  32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        clear_n      = 1'b1;
        bus.habilita = 1'b1;
        hold('0, 2);

        // Clean press
        clr_cnt();
        hold(4'b0010, 20);
        hold('0, 10);
        chk("clean_count",   32'(n_feita),     32'd1);
        chk("clean_latency", 32'(first_feita), 32'(5 + c_lat));
        chk("clean_jogada",  32'(bus.jogada),  32'h2);
        chk("clean_err",     32'(n_err),       32'd0);

        // Press bounce, then release bounce
        clr_cnt();
        hold(4'b0100, 1); hold('0, 1); hold(4'b0100, 2); hold('0, 1);
        hold(4'b0100, 12);
        hold('0, 1); hold(4'b0100, 1); hold('0, 12);
        chk("bounce_count",  32'(n_feita),    32'd1);
        chk("bounce_jogada", 32'(bus.jogada), 32'h4);

        // Multiple buttons
        clr_cnt();
        hold(4'b0011, 10);
        hold('0, 10);
        chk("multi_err",    32'(n_err),      32'd1);
        chk("multi_feita",  32'(n_feita),    32'd0);
        chk("multi_jogada", 32'(bus.jogada), 32'h4);

        // Gating by habilita
        clr_cnt();
        bus.habilita = 1'b0;
        hold(4'b1000, 8);
        chk("gate_ocupado", 32'(bus.ocupado), 32'd0);
        chk("gate_feita",   32'(n_feita),     32'd0);
        clr_cnt();
        bus.habilita = 1'b1;
        hold(4'b1000, 12);
        chk("gate_count",   32'(n_feita),     32'd1);
        chk("gate_latency", 32'(first_feita), 32'd5);
        chk("gate_jogada",  32'(bus.jogada),  32'h8);
        hold('0, 10);

        // Reset in the middle of filtering
        clr_cnt();
        bus.botoes = 4'b0100;
        repeat (3 + c_lat) step();
        clear_n    = 1'b0;
        bus.botoes = '0;
        step();
        clear_n = 1'b1;
        chk("mrst_jogada",  32'(bus.jogada),  32'd0);
        chk("mrst_ocupado", 32'(bus.ocupado), 32'd0);
        hold('0, 6);
        chk("mrst_nofeita", 32'(n_feita), 32'd0);
        hold(4'b0001, 12);
        hold('0, 10);
        chk("mrst_count",  32'(n_feita),    32'd1);
        chk("mrst_jogada", 32'(bus.jogada), 32'h1);

        // Random patterns, durations, enables and occasional resets
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r < 5)      rb = N'(1) << $urandom_range(0, N - 1);
            else if (r < 7) rb = N'($urandom_range(0, (1 << N) - 1));
            else            rb = '0;
            bus.habilita = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 29) == 0) begin
                clear_n = 1'b0;
                step();
                clear_n = 1'b1;
            end
            hold(rb, $urandom_range(1, 12));
        end
        hold('0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
